// File: rtl/mu_wb_arbiter.sv
// rtl/mu_wb_arbiter.sv - merges multiply results onto the shared register-file write port
module mu_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     mu_done,
  input  logic                     mu_wen,
  input  logic [4:0]               mu_reg_rd,
  input  logic [31:0]              mu_wdata,
  input  logic                     pipe_wen,
  input  logic [4:0]               pipe_reg_rd,
  input  logic [31:0]              pipe_wdata,
  input  logic [4:0]               rs1_addr,
  input  logic [4:0]               rs2_addr,
  output logic                     rf_wen,
  output logic [4:0]               rf_reg_rd,
  output logic [31:0]              rf_wdata,
  output logic                     wb_stall,
  output logic                     rs1_pending,
  output logic                     rs2_pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             ent_valid [DEPTH];
  logic [4:0]       ent_rd    [DEPTH];
  logic [31:0]      ent_data  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic mu_push;
  logic pipe_req;
  logic full;
  logic empty;
  logic pop;
  logic bypass;
  logic push;
  logic pipe_accept;
  logic push_valid;

  assign mu_push     = mu_done & mu_wen & (mu_reg_rd != 5'd0);
  assign pipe_req    = pipe_wen & (pipe_reg_rd != 5'd0);
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign pipe_accept = pipe_req & ~full;
  assign push        = mu_push & ~bypass;
  // Pipe writes are always younger, so a same-register multiply result is dead on arrival.
  assign push_valid  = ~(pipe_accept && (mu_reg_rd == pipe_reg_rd));
  assign fifo_count  = count;

  always_comb begin
    rf_wen    = 1'b0;
    rf_reg_rd = 5'd0;
    rf_wdata  = 32'd0;
    wb_stall  = 1'b0;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (full) begin
      rf_wen    = ent_valid[rd_ptr];
      rf_reg_rd = ent_rd[rd_ptr];
      rf_wdata  = ent_data[rd_ptr];
      wb_stall  = pipe_req;
      pop       = 1'b1;
    end else if (pipe_req) begin
      rf_wen    = 1'b1;
      rf_reg_rd = pipe_reg_rd;
      rf_wdata  = pipe_wdata;
    end else if (!empty) begin
      rf_wen    = ent_valid[rd_ptr];
      rf_reg_rd = ent_rd[rd_ptr];
      rf_wdata  = ent_data[rd_ptr];
      pop       = 1'b1;
    end else if (mu_push) begin
      rf_wen    = 1'b1;
      rf_reg_rd = mu_reg_rd;
      rf_wdata  = mu_wdata;
      bypass    = 1'b1;
    end
  end

  always_comb begin
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == rs1_addr)) rs1_pending = 1'b1;
      if (ent_valid[i] && (ent_rd[i] == rs2_addr)) rs2_pending = 1'b1;
    end
    if (rs1_addr == 5'd0) rs1_pending = 1'b0;
    if (rs2_addr == 5'd0) rs2_pending = 1'b0;
  end

  // Later assignments win: invalidate, then retire the head, then write the tail.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_rd[i]    <= 5'd0;
        ent_data[i]  <= 32'd0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pipe_accept) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_rd[i] == pipe_reg_rd) ent_valid[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        ent_valid[wr_ptr] <= push_valid;
        ent_rd[wr_ptr]    <= mu_reg_rd;
        ent_data[wr_ptr]  <= mu_wdata;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mu_wb_arbiter.sv
// tb/tb_mu_wb_arbiter.sv - directed self-checking bench for mu_wb_arbiter
module tb_mu_wb_arbiter;

  logic        CLK;
  logic        nRST;
  logic        mu_done;
  logic        mu_wen;
  logic [4:0]  mu_reg_rd;
  logic [31:0] mu_wdata;
  logic        pipe_wen;
  logic [4:0]  pipe_reg_rd;
  logic [31:0] pipe_wdata;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rf_wen;
  logic [4:0]  rf_reg_rd;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic        rs1_pending;
  logic        rs2_pending;
  logic [1:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  mu_wb_arbiter #(.DEPTH(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .mu_done(mu_done), .mu_wen(mu_wen), .mu_reg_rd(mu_reg_rd), .mu_wdata(mu_wdata),
    .pipe_wen(pipe_wen), .pipe_reg_rd(pipe_reg_rd), .pipe_wdata(pipe_wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rf_wen(rf_wen), .rf_reg_rd(rf_reg_rd), .rf_wdata(rf_wdata),
    .wb_stall(wb_stall), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .fifo_count(fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic set_mu(input logic d, input logic w, input logic [4:0] rd, input logic [31:0] data);
    mu_done = d; mu_wen = w; mu_reg_rd = rd; mu_wdata = data;
  endtask

  task automatic set_pipe(input logic w, input logic [4:0] rd, input logic [31:0] data);
    pipe_wen = w; pipe_reg_rd = rd; pipe_wdata = data;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge CLK);
    set_mu(0, 0, 0, 0);
    set_pipe(0, 0, 0);
    rs1_addr = 0; rs2_addr = 0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    set_mu(0, 0, 0, 0); set_pipe(0, 0, 0); rs1_addr = 0; rs2_addr = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); nRST = 1'b1; #1;
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL reset_rf_wen got %0b want 0", rf_wen); end
    n_cmp++; if (rf_reg_rd !== 5'd0 || rf_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_rf_addr_data got %0d/%h want 0/0", rf_reg_rd, rf_wdata); end
    n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL reset_wb_stall got %0b want 0", wb_stall); end
    n_cmp++; if (fifo_count !== 2'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_cmp++; if ({rs1_pending, rs2_pending} !== 2'b00) begin n_bad++; $display("FAIL reset_pending got %b want 00", {rs1_pending, rs2_pending}); end
  endtask

  task automatic test_bypass();
    next_cycle();
    set_mu(1, 1, 5'd5, 32'h1234); #1;
    n_cmp++; if (rf_wen !== 1'b1 || rf_reg_rd !== 5'd5 || rf_wdata !== 32'h1234) begin n_bad++; $display("FAIL bypass_write got %0b/%0d/%h want 1/5/00001234", rf_wen, rf_reg_rd, rf_wdata); end
    next_cycle(); rs1_addr = 5'd5; #1;
    n_cmp++; if (fifo_count !== 2'd0) begin n_bad++; $display("FAIL bypass_count got %0d want 0", fifo_count); end
    n_cmp++; if (rs1_pending !== 1'b0 || rf_wen !== 1'b0) begin n_bad++; $display("FAIL bypass_after got pend=%0b wen=%0b want 0/0", rs1_pending, rf_wen); end
  endtask

  task automatic test_collision();
    next_cycle();
    set_mu(1, 1, 5'd6, 32'hAA); set_pipe(1, 5'd7, 32'hBB); #1;
    n_cmp++; if (rf_wen !== 1'b1 || rf_reg_rd !== 5'd7 || rf_wdata !== 32'hBB || wb_stall !== 1'b0) begin n_bad++; $display("FAIL collide_pipe got %0b/%0d/%h stall=%0b want 1/7/000000bb stall=0", rf_wen, rf_reg_rd, rf_wdata, wb_stall); end
    next_cycle(); rs1_addr = 5'd6; #1;
    n_cmp++; if (fifo_count !== 2'd1) begin n_bad++; $display("FAIL collide_count got %0d want 1", fifo_count); end
    n_cmp++; if (rs1_pending !== 1'b1) begin n_bad++; $display("FAIL collide_pending got %0b want 1", rs1_pending); end
    n_cmp++; if (rf_wen !== 1'b1 || rf_reg_rd !== 5'd6 || rf_wdata !== 32'hAA) begin n_bad++; $display("FAIL collide_drain got %0b/%0d/%h want 1/6/000000aa", rf_wen, rf_reg_rd, rf_wdata); end
    next_cycle(); rs1_addr = 5'd6; #1;
    n_cmp++; if (fifo_count !== 2'd0 || rs1_pending !== 1'b0) begin n_bad++; $display("FAIL collide_empty got cnt=%0d pend=%0b want 0/0", fifo_count, rs1_pending); end
  endtask

  task automatic test_full();
    next_cycle();
    set_mu(1, 1, 5'd8, 32'h8); set_pipe(1, 5'd1, 32'h1);
    next_cycle();
    set_mu(1, 1, 5'd9, 32'h9); set_pipe(1, 5'd2, 32'h2);
    next_cycle();
    set_mu(1, 1, 5'd11, 32'hB); set_pipe(1, 5'd10, 32'hA); rs1_addr = 5'd8; rs2_addr = 5'd9; #1;
    n_cmp++; if (fifo_count !== 2'd2 || {rs1_pending, rs2_pending} !== 2'b11) begin n_bad++; $display("FAIL full_state got cnt=%0d pend=%b want 2/11", fifo_count, {rs1_pending, rs2_pending}); end
    n_cmp++; if (wb_stall !== 1'b1) begin n_bad++; $display("FAIL full_stall got %0b want 1", wb_stall); end
    n_cmp++; if (rf_wen !== 1'b1 || rf_reg_rd !== 5'd8 || rf_wdata !== 32'h8) begin n_bad++; $display("FAIL full_head got %0b/%0d/%h want 1/8/00000008", rf_wen, rf_reg_rd, rf_wdata); end
    next_cycle(); set_pipe(1, 5'd10, 32'hA); rs1_addr = 5'd11; #1;
    n_cmp++; if (fifo_count !== 2'd2 || rs1_pending !== 1'b1) begin n_bad++; $display("FAIL full_push_pop got cnt=%0d pend=%0b want 2/1", fifo_count, rs1_pending); end
    n_cmp++; if (wb_stall !== 1'b1 || rf_reg_rd !== 5'd9 || rf_wen !== 1'b1) begin n_bad++; $display("FAIL full_second got stall=%0b rd=%0d wen=%0b want 1/9/1", wb_stall, rf_reg_rd, rf_wen); end
    next_cycle(); set_pipe(1, 5'd10, 32'hA); #1;
    n_cmp++; if (wb_stall !== 1'b0 || rf_wen !== 1'b1 || rf_reg_rd !== 5'd10 || rf_wdata !== 32'hA) begin n_bad++; $display("FAIL full_release got stall=%0b %0b/%0d/%h want 0 1/10/0000000a", wb_stall, rf_wen, rf_reg_rd, rf_wdata); end
    next_cycle(); #1;
    n_cmp++; if (fifo_count !== 2'd1 || rf_wen !== 1'b1 || rf_reg_rd !== 5'd11 || rf_wdata !== 32'hB) begin n_bad++; $display("FAIL full_tail got cnt=%0d %0b/%0d/%h want 1 1/11/0000000b", fifo_count, rf_wen, rf_reg_rd, rf_wdata); end
    next_cycle(); #1;
    n_cmp++; if (fifo_count !== 2'd0) begin n_bad++; $display("FAIL full_drained got %0d want 0", fifo_count); end
  endtask

  task automatic test_waw();
    next_cycle();
    set_mu(1, 1, 5'd12, 32'h1); set_pipe(1, 5'd1, 32'h0);
    next_cycle();
    set_pipe(1, 5'd12, 32'h2); #1;
    n_cmp++; if (rf_wen !== 1'b1 || rf_reg_rd !== 5'd12 || rf_wdata !== 32'h2) begin n_bad++; $display("FAIL waw_pipe got %0b/%0d/%h want 1/12/00000002", rf_wen, rf_reg_rd, rf_wdata); end
    next_cycle(); rs1_addr = 5'd12; #1;
    n_cmp++; if (fifo_count !== 2'd1 || rs1_pending !== 1'b0) begin n_bad++; $display("FAIL waw_invalid got cnt=%0d pend=%0b want 1/0", fifo_count, rs1_pending); end
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL waw_pop_wen got %0b want 0", rf_wen); end
    next_cycle();
    set_mu(1, 1, 5'd13, 32'h3); set_pipe(1, 5'd13, 32'h4); #1;
    n_cmp++; if (fifo_count !== 2'd0 || rf_wdata !== 32'h4) begin n_bad++; $display("FAIL waw_same_cycle got cnt=%0d data=%h want 0/00000004", fifo_count, rf_wdata); end
    next_cycle(); rs2_addr = 5'd13; #1;
    n_cmp++; if (fifo_count !== 2'd1 || rs2_pending !== 1'b0 || rf_wen !== 1'b0) begin n_bad++; $display("FAIL waw_dead_entry got cnt=%0d pend=%0b wen=%0b want 1/0/0", fifo_count, rs2_pending, rf_wen); end
    next_cycle(); #1;
    n_cmp++; if (fifo_count !== 2'd0) begin n_bad++; $display("FAIL waw_drained got %0d want 0", fifo_count); end
  endtask

  task automatic test_x0();
    next_cycle();
    set_mu(1, 1, 5'd0, 32'hDEAD); #1;
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL x0_mu_wen got %0b want 0", rf_wen); end
    next_cycle();
    set_pipe(1, 5'd0, 32'hBEEF); #1;
    n_cmp++; if (rf_wen !== 1'b0 || wb_stall !== 1'b0 || fifo_count !== 2'd0) begin n_bad++; $display("FAIL x0_pipe got wen=%0b stall=%0b cnt=%0d want 0/0/0", rf_wen, wb_stall, fifo_count); end
    next_cycle();
    set_mu(1, 0, 5'd3, 32'h3); #1;
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL nowen_mu got %0b want 0", rf_wen); end
    next_cycle(); #1;
    n_cmp++; if (fifo_count !== 2'd0) begin n_bad++; $display("FAIL x0_count got %0d want 0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    set_mu(1, 1, 5'd20, 32'h20); set_pipe(1, 5'd1, 32'h0);
    next_cycle();
    set_mu(1, 1, 5'd21, 32'h21); set_pipe(1, 5'd2, 32'h0);
    next_cycle(); rs1_addr = 5'd20; rs2_addr = 5'd21; #1;
    n_cmp++; if (fifo_count !== 2'd2 || {rs1_pending, rs2_pending} !== 2'b11) begin n_bad++; $display("FAIL rst_prefill got cnt=%0d pend=%b want 2/11", fifo_count, {rs1_pending, rs2_pending}); end
    nRST = 1'b0; #1;
    n_cmp++; if (fifo_count !== 2'd0 || {rs1_pending, rs2_pending} !== 2'b00 || rf_wen !== 1'b0) begin n_bad++; $display("FAIL rst_async got cnt=%0d pend=%b wen=%0b want 0/00/0", fifo_count, {rs1_pending, rs2_pending}, rf_wen); end
    @(negedge CLK); nRST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (rf_wen !== 1'b0 || fifo_count !== 2'd0) begin n_bad++; $display("FAIL rst_after_%0d got wen=%0b cnt=%0d want 0/0", i, rf_wen, fifo_count); end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_full();
    test_waw();
    test_x0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
